gate_sequencer: RTL and testbench
=================================

Name: gate_sequencer

Overview:
- Timed, triggered controller for the register-gated dual-channel passthrough.
- Replaces the static Control bits with a sequenced gate: arm, wait for a trigger, wait a delay, then open the gate for N cycles, repeated P times with a closed gap between openings.
- Sits inside CustomWrapper between InputA/B and OutputA/B. Configuration is driven from Control registers and the trigger from ExtTrig.

Parameters:
- CNT_W, 32, width of the delay, open and gap counters and their config inputs.
- RPT_W, 16, width of the repeat count and the pulse counter.
- DATA_W, 16, width of the signed data channels.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- arm  in  1  level; 1 enables the sequencer, 0 aborts and returns it to IDLE.
- soft_trig  in  1  register trigger; its rising edge is the trigger event.
- ext_trig  in  1  asynchronous external trigger; its rising edge is the trigger event.
- delay_cycles  in  CNT_W  cycles from trigger event to first opening.
- open_cycles  in  CNT_W  gate-open length per pulse; 0 is treated as 1.
- gap_cycles  in  CNT_W  closed length between pulses; 0 is treated as 1.
- repeat_count  in  RPT_W  number of pulses; 0 means continuous until arm falls.
- ch_en  in  2  per-channel enable: bit0 = A, bit1 = B.
- in_a, in_b  in  DATA_W signed  data inputs.
- out_a, out_b  out  DATA_W signed  gated data outputs, registered.
- gate_open  out  1  high while the state is OPEN.
- busy  out  1  high in DELAY, OPEN and GAP.
- armed  out  1  high in ARMED.
- done  out  1  high in DONE.
- pulse_cnt  out  RPT_W  pulses completed since the last arm.

Behaviour:
- Reset: state IDLE. All outputs are 0, all counters 0, synchronizer flops 0.
- Configuration: delay/open/gap/repeat/ch_en are latched into shadow registers on the IDLE->ARMED transition. Later changes have no effect until the next arm.
- ext_trig synchronization: 2-flop synchronizer, then a third flop for edge detect.
  - ext event = sync2 & ~sync3, combinational.
  - If ext_trig rises before clock edge 0, the event is asserted in cycle 2.
- soft_trig: one flop for edge detect. The event is asserted in the cycle soft_trig is first seen high.
- trig_evt = ext event OR soft event. Both in the same cycle count as one event.
- States: IDLE, ARMED, DELAY, OPEN, GAP, DONE.
- IDLE -> ARMED when arm=1. pulse_cnt is cleared on this transition.
- ARMED -> trig_evt with delay=0 goes to OPEN; with delay>0 it loads the counter with delay-1 and goes to DELAY.
- DELAY: decrement the counter; at 0 go to OPEN.
- Entering OPEN: load the counter with max(open,1)-1.
- OPEN at count 0:
  - increment pulse_cnt;
  - if repeat_count != 0 and pulse_cnt+1 == repeat_count, go to DONE;
  - otherwise load max(gap,1)-1 and go to GAP.
- GAP at count 0: go to OPEN.
- DONE: hold until arm=0, then go to IDLE. Re-arming requires an arm 0->1.
- arm=0 in any state other than IDLE: go to IDLE on the next edge. The gate closes that edge, and done/busy/armed drop.
- trig_evt outside ARMED is ignored (no retrigger, no queueing).
- Timing: with a trigger event in cycle t, gate_open is high in cycles t+1+D through t+D+max(O,1).
- Data path:
  - out_x(k+1) = (gate_open(k) & ch_en_shadow[x]) ? in_x(k) : 0.
  - Latency is 1 cycle; values pass through bit-exact.
- pulse_cnt saturates at all-ones in continuous mode.
- Asynchronous Reset mid-sequence: immediate IDLE, outputs 0.

Decomposition:
- Package gate_seq_pkg holds:
  - the state enum (IDLE, ARMED, DELAY, OPEN, GAP, DONE);
  - default widths CNT_W/RPT_W/DATA_W;
  - a function max1(x) returning x==0 ? 1 : x.
- Sub-module gate_seq_trig: the 2-flop ext_trig synchronizer, the edge-detect flops for ext and soft triggers, and trig_evt. It has its own Clk and Reset.
- The state machine, counters and output registers stay in gate_sequencer.

Test Plan:
- Reset release, then arm=1. Expect armed=1 the next cycle; out_a/out_b = 0 and gate_open = 0.
- delay=0, open=4, repeat=1, soft_trig rising in cycle 10, in_a=16'h1234. Expect:
  - gate_open high in cycles 11-14;
  - out_a=16'h1234 in cycles 12-15, 0 otherwise;
  - done=1 from cycle 15, pulse_cnt=1.
- ext_trig rising before edge 20, delay=5, open=2, gap=3, repeat=3, ch_en=2'b10. Expect:
  - event in cycle 22;
  - gate_open in 28-29, 33-34 and 38-39;
  - out_a always 0; out_b gated;
  - done=1 from cycle 40, pulse_cnt=3.
- open=0, gap=0, repeat=0 (continuous). Expect gate_open toggling 1,0,1,0 each cycle until arm=0; after arm falls, gate_open=0 and state IDLE within 1 cycle.
- Retriggers during DELAY/OPEN, and a soft+ext trigger in the same cycle. Expect exactly one sequence and no extra pulses.
- Reset asserted mid-OPEN. Expect all outputs 0 immediately. After release, arm 0->1 restarts cleanly with pulse_cnt=0.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate sequencer: state encoding, default widths
// and the zero-means-one length helper.
package gate_seq_pkg;

   localparam int DEF_CNT_W  = 32;
   localparam int DEF_RPT_W  = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      OPEN,
      GAP,
      DONE
   } state_t;

   function automatic logic [DEF_CNT_W-1:0] max1(input logic [DEF_CNT_W-1:0] x);
      return (x == '0) ? {{(DEF_CNT_W-1){1'b0}}, 1'b1} : x;
   endfunction

endpackage

// File: rtl/gate_seq_trig.sv
// Trigger front end: synchronizes ext_trig, edge-detects both trigger sources and
// merges them into a single one-cycle trigger event.
module gate_seq_trig (
   input  logic Clk,
   input  logic Reset,
   input  logic soft_trig,
   input  logic ext_trig,
   output logic trig_evt
);

   logic sync1, sync2, sync3;
   logic soft_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         soft_q <= 1'b0;
      end else begin
         sync1  <= ext_trig;
         sync2  <= sync1;
         sync3  <= sync2;
         soft_q <= soft_trig;
      end
   end

   // A simultaneous soft and ext edge collapses into one event.
   assign trig_evt = (sync2 & ~sync3) | (soft_trig & ~soft_q);

endmodule

// File: rtl/gate_sequencer.sv
// Triggered gate controller: arm, wait for trigger, delay, then open the dual-channel
// data gate for a programmed length, repeated with closed gaps in between.
module gate_sequencer
   import gate_seq_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int RPT_W  = DEF_RPT_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     arm,
   input  logic                     soft_trig,
   input  logic                     ext_trig,
   input  logic [CNT_W-1:0]         delay_cycles,
   input  logic [CNT_W-1:0]         open_cycles,
   input  logic [CNT_W-1:0]         gap_cycles,
   input  logic [RPT_W-1:0]         repeat_count,
   input  logic [1:0]               ch_en,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   output logic signed [DATA_W-1:0] out_a,
   output logic signed [DATA_W-1:0] out_b,
   output logic                     gate_open,
   output logic                     busy,
   output logic                     armed,
   output logic                     done,
   output logic [RPT_W-1:0]         pulse_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [RPT_W-1:0] RPT_ONE = 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [RPT_W-1:0] pulse_nxt, pulse_inc;
   logic             latch;
   logic             trig_evt;
   logic             last_pulse;

   logic [CNT_W-1:0] dly_sh, open_sh, gap_sh;
   logic [RPT_W-1:0] rpt_sh;
   logic [1:0]       en_sh;
   logic [CNT_W-1:0] open_ld, gap_ld;

   gate_seq_trig u_trig (
      .Clk      (Clk),
      .Reset    (Reset),
      .soft_trig(soft_trig),
      .ext_trig (ext_trig),
      .trig_evt (trig_evt)
   );

   assign open_ld    = max1(open_sh) - CNT_ONE;
   assign gap_ld     = max1(gap_sh) - CNT_ONE;
   assign pulse_inc  = pulse_cnt + RPT_ONE;
   assign last_pulse = (rpt_sh != '0) && (pulse_inc == rpt_sh);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pulse_cnt <= '0;
         dly_sh    <= '0;
         open_sh   <= '0;
         gap_sh    <= '0;
         rpt_sh    <= '0;
         en_sh     <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pulse_cnt <= pulse_nxt;
         if (latch) begin
            dly_sh  <= delay_cycles;
            open_sh <= open_cycles;
            gap_sh  <= gap_cycles;
            rpt_sh  <= repeat_count;
            en_sh   <= ch_en;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = pulse_cnt;
      latch     = 1'b0;
      // Dropping arm aborts from any active state, ahead of every other transition.
      if (state != IDLE && !arm) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  state_nxt = ARMED;
                  pulse_nxt = '0;
                  latch     = 1'b1;
               end
            end
            ARMED: begin
               if (trig_evt) begin
                  if (dly_sh == '0) begin
                     state_nxt = OPEN;
                     cnt_nxt   = open_ld;
                  end else begin
                     state_nxt = DELAY;
                     cnt_nxt   = dly_sh - CNT_ONE;
                  end
               end
            end
            DELAY, GAP: begin
               if (cnt == '0) begin
                  state_nxt = OPEN;
                  cnt_nxt   = open_ld;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            OPEN: begin
               if (cnt == '0) begin
                  // Continuous mode holds the count at all-ones rather than wrapping.
                  pulse_nxt = (&pulse_cnt) ? pulse_cnt : pulse_inc;
                  if (last_pulse) begin
                     state_nxt = DONE;
                  end else begin
                     state_nxt = GAP;
                     cnt_nxt   = gap_ld;
                  end
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            DONE: begin
               state_nxt = DONE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign gate_open = (state == OPEN);
   assign busy      = (state == DELAY) || (state == OPEN) || (state == GAP);
   assign armed     = (state == ARMED);
   assign done      = (state == DONE);

   // Data path: one register stage, bit-exact passthrough while the gate is open.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         out_a <= '0;
         out_b <= '0;
      end else begin
         out_a <= (gate_open && en_sh[0]) ? in_a : '0;
         out_b <= (gate_open && en_sh[1]) ? in_b : '0;
      end
   end

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a timeline-based reference model.
module tb_gate_sequencer;

   logic               Clk;
   logic               Reset;
   logic               arm;
   logic               soft_trig;
   logic               ext_trig;
   logic [31:0]        delay_cycles;
   logic [31:0]        open_cycles;
   logic [31:0]        gap_cycles;
   logic [15:0]        repeat_count;
   logic [1:0]         ch_en;
   logic signed [15:0] in_a;
   logic signed [15:0] in_b;
   logic signed [15:0] out_a;
   logic signed [15:0] out_b;
   logic               gate_open;
   logic               busy;
   logic               armed;
   logic               done;
   logic [15:0]        pulse_cnt;

   gate_sequencer dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .arm         (arm),
      .soft_trig   (soft_trig),
      .ext_trig    (ext_trig),
      .delay_cycles(delay_cycles),
      .open_cycles (open_cycles),
      .gap_cycles  (gap_cycles),
      .repeat_count(repeat_count),
      .ch_en       (ch_en),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_a       (out_a),
      .out_b       (out_b),
      .gate_open   (gate_open),
      .busy        (busy),
      .armed       (armed),
      .done        (done),
      .pulse_cnt   (pulse_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tracks idle/armed/running and derives the gate timeline
   // arithmetically from the trigger cycle and the latched configuration.
   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_RUN   = 2;

   int                 m_mode;
   longint             cyc;
   longint             t_evt;
   longint             sh_dly, sh_open, sh_gap, sh_rpt;
   logic [1:0]         sh_en;
   longint             held_pc;
   logic signed [15:0] exp_a, exp_b;
   bit                 ext_prev, soft_prev;
   longint             ext_q[$];
   bit                 rnd_data;
   int                 gcnt;
   longint             first_open;

   function automatic void model_outputs(input longint c, output bit g, output bit bsy,
                                         output bit arm_o, output bit dn, output longint pc);
      longint op, gp, per, rel, n;
      g = 0; bsy = 0; arm_o = 0; dn = 0; pc = held_pc;
      case (m_mode)
         M_ARMED: begin
            arm_o = 1;
            pc    = 0;
         end
         M_RUN: begin
            op  = (sh_open == 0) ? 1 : sh_open;
            gp  = (sh_gap == 0) ? 1 : sh_gap;
            per = op + gp;
            rel = c - (t_evt + sh_dly + 1);
            if (rel < 0) begin
               bsy = 1;
               pc  = 0;
            end else begin
               n = (rel < op) ? 0 : (rel - op) / per + 1;
               if (sh_rpt != 0 && n > sh_rpt) n = sh_rpt;
               if (n > 65535) n = 65535;
               pc = n;
               if (sh_rpt != 0 && rel >= sh_rpt * per - gp) begin
                  dn = 1;
               end else begin
                  bsy = 1;
                  g   = ((rel % per) < op);
               end
            end
         end
         default: ;
      endcase
   endfunction

   task automatic model_reset();
      m_mode    = M_IDLE;
      held_pc   = 0;
      exp_a     = '0;
      exp_b     = '0;
      ext_prev  = 0;
      soft_prev = 0;
      ext_q.delete();
      sh_dly = 0; sh_open = 0; sh_gap = 0; sh_rpt = 0; sh_en = '0;
   endtask

   task automatic model_edge();
      bit g, b, a, d, trig;
      longint pc;
      model_outputs(cyc, g, b, a, d, pc);
      exp_a = (g && sh_en[0]) ? in_a : 16'sd0;
      exp_b = (g && sh_en[1]) ? in_b : 16'sd0;
      // An ext_trig rise becomes a trigger event two cycles later.
      if (ext_trig && !ext_prev) ext_q.push_back(cyc + 2);
      ext_prev  = ext_trig;
      trig      = soft_trig && !soft_prev;
      soft_prev = soft_trig;
      if (ext_q.size() > 0 && ext_q[0] == cyc) begin
         trig = 1;
         void'(ext_q.pop_front());
      end
      if (m_mode != M_IDLE && !arm) begin
         m_mode  = M_IDLE;
         held_pc = pc;
      end else if (m_mode == M_IDLE && arm) begin
         m_mode  = M_ARMED;
         held_pc = 0;
         sh_dly  = delay_cycles;
         sh_open = open_cycles;
         sh_gap  = gap_cycles;
         sh_rpt  = repeat_count;
         sh_en   = ch_en;
      end else if (m_mode == M_ARMED && trig) begin
         m_mode = M_RUN;
         t_evt  = cyc;
      end
      cyc++;
   endtask

   task automatic check_all();
      bit g, b, a, d;
      longint pc;
      model_outputs(cyc, g, b, a, d, pc);
      check("gate_open", gate_open, g);
      check("busy", busy, b);
      check("armed", armed, a);
      check("done", done, d);
      check("pulse_cnt", pulse_cnt, pc);
      check("out_a", out_a, exp_a);
      check("out_b", out_b, exp_b);
   endtask

   task automatic step();
      if (rnd_data) begin
         in_a = 16'($urandom);
         in_b = 16'($urandom);
      end
      model_edge();
      @(negedge Clk);
      check_all();
      if (gate_open) begin
         gcnt++;
         if (first_open < 0) first_open = cyc;
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_cfg(input int d, input int o, input int g, input int p, input int en);
      delay_cycles = 32'(d);
      open_cycles  = 32'(o);
      gap_cycles   = 32'(g);
      repeat_count = 16'(p);
      ch_en        = 2'(en);
   endtask

   task automatic rand_cfg();
      set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)));
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      longint t;
      bit found;
      Reset = 1'b1; arm = 1'b0; soft_trig = 1'b0; ext_trig = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      in_a = '0; in_b = '0;
      rnd_data = 1; gcnt = 0; first_open = -1; cyc = 0;
      model_reset();

      // Reset state
      repeat (3) @(negedge Clk);
      check("rst_gate_open", gate_open, 0);
      check("rst_busy", busy, 0);
      check("rst_armed", armed, 0);
      check("rst_done", done, 0);
      check("rst_pulse_cnt", pulse_cnt, 0);
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      Reset = 1'b0;
      cycles(2);

      // Arm, then soft trigger: delay 0, open 4, repeat 1
      rnd_data = 0; in_a = 16'sh1234; in_b = 16'sh0BCD;
      set_cfg(0, 4, 0, 1, 1);
      arm = 1'b1;
      step();
      check("arm_armed", armed, 1);
      check("arm_gate", gate_open, 0);
      cycles(3);
      t = cyc; soft_trig = 1'b1; gcnt = 0; first_open = -1;
      step();
      soft_trig = 1'b0;
      cycles(8);
      check("s1_first_open", first_open, t + 1);
      check("s1_open_len", gcnt, 4);
      check("s1_done", done, 1);
      check("s1_pulse_cnt", pulse_cnt, 1);
      check("s1_out_a_closed", out_a, 0);

      // Ext trigger: delay 5, open 2, gap 3, repeat 3, channel B only
      rnd_data = 1;
      arm = 1'b0;
      cycles(2);
      set_cfg(5, 2, 3, 3, 2);
      arm = 1'b1;
      cycles(2);
      set_cfg(1, 1, 1, 1, 3);
      t = cyc; ext_trig = 1'b1; gcnt = 0; first_open = -1;
      cycles(4);
      ext_trig = 1'b0;
      cycles(22);
      check("s2_first_open", first_open, t + 8);
      check("s2_open_total", gcnt, 6);
      check("s2_done", done, 1);
      check("s2_pulse_cnt", pulse_cnt, 3);

      // Continuous mode with zero open/gap, then abort
      arm = 1'b0;
      cycles(1);
      set_cfg(0, 0, 0, 0, 3);
      arm = 1'b1;
      cycles(2);
      soft_trig = 1'b1;
      step();
      soft_trig = 1'b0;
      cycles(11);
      arm = 1'b0;
      step();
      check("cont_abort_gate", gate_open, 0);
      check("cont_abort_busy", busy, 0);

      // Retriggers during DELAY/OPEN and a simultaneous soft+ext event
      cycles(1);
      set_cfg(3, 3, 2, 2, 1);
      arm = 1'b1;
      step();
      ext_trig = 1'b1;
      cycles(2);
      soft_trig = 1'b1; gcnt = 0;
      step();
      for (int i = 0; i < 24; i++) begin
         soft_trig = (i % 2 == 1);
         if (i == 3) ext_trig = 1'b0;
         if (i == 6) ext_trig = 1'b1;
         step();
      end
      soft_trig = 1'b0; ext_trig = 1'b0;
      check("retrig_open_total", gcnt, 6);
      check("retrig_done", done, 1);
      check("retrig_pulse_cnt", pulse_cnt, 2);

      // Asynchronous reset in the middle of an OPEN window
      arm = 1'b0;
      cycles(2);
      set_cfg(0, 10, 1, 0, 3);
      arm = 1'b1;
      step();
      soft_trig = 1'b1;
      step();
      soft_trig = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (gate_open) found = 1;
      end
      if (!found) check("mid_rst_reach_open", 0, 1);
      cycles(2);
      #2;
      Reset = 1'b1; arm = 1'b0;
      #1;
      check("mid_rst_gate", gate_open, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_a", out_a, 0);
      check("mid_rst_out_b", out_b, 0);
      check("mid_rst_pulse_cnt", pulse_cnt, 0);
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      step();
      set_cfg(1, 2, 1, 2, 3);
      arm = 1'b1;
      step();
      check("rearm_armed", armed, 1);
      check("rearm_pulse_cnt", pulse_cnt, 0);
      soft_trig = 1'b1;
      step();
      soft_trig = 1'b0;
      cycles(10);
      check("rearm_done", done, 1);

      // Randomized episodes
      for (int e = 0; e < 40; e++) begin
         arm = 1'b0; soft_trig = 1'b0; ext_trig = 1'b0;
         cycles(int'($urandom_range(4, 6)));
         rand_cfg();
         arm = 1'b1;
         for (int k = 0; k < 50; k++) begin
            soft_trig = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) ext_trig = ~ext_trig;
            if ($urandom_range(0, 3) == 0) rand_cfg();
            if ($urandom_range(0, 79) == 0) arm = 1'b0;
            else if (!arm && $urandom_range(0, 3) == 0) arm = 1'b1;
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
